// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: inter-stage pipeline register with valid/ready handshake,
// a two-entry (main + skid) buffer, synchronous flush that injects a bubble,
// and a saturating count of stalled output cycles.
module pipe_stage_latch #(
  parameter int              DATA_W  = 32,
  parameter int              IR_W    = 32,
  parameter int              FLAGS_W = 1,
  parameter logic [IR_W-1:0] NOP_IR  = {IR_W{1'b0}}
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_o,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [IR_W-1:0]    in_ir,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_o,
  output logic [DATA_W-1:0]  out_b,
  output logic [IR_W-1:0]    out_ir,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [15:0]        stall_cycles
);

  // One word is the concatenation {o, b, ir, flags}.
  localparam int WORD_W = 2 * DATA_W + IR_W + FLAGS_W;
  localparam logic [WORD_W-1:0] BUBBLE = {{(2 * DATA_W){1'b0}}, NOP_IR, {FLAGS_W{1'b0}}};

  // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   main_word;
  logic [WORD_W-1:0]   main_next;
  logic [WORD_W-1:0]   skid_word;
  logic [WORD_W-1:0]   skid_next;
  logic [WORD_W-1:0]   in_word;
  logic [15:0]         stall_count;

  assign in_word = {in_o, in_b, in_ir, in_flags};

  // Handshake flags come straight from the state register, so neither
  // in_ready nor out_valid has a combinational path from any input.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);

  // The main entry drives the outputs directly; it holds BUBBLE whenever it is
  // invalid so an empty stage always presents a NOP downstream.
  assign {out_o, out_b, out_ir, out_flags} = main_word;
  assign stall_cycles = stall_count;

  // Next-state and next-entry selection; flush overrides every transition.
  always_comb begin
    state_next = state;
    main_next  = main_word;
    skid_next  = skid_word;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          main_next  = in_word;
          state_next = ONE;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (in_valid) begin
            main_next = in_word;
          end else begin
            main_next  = BUBBLE;
            state_next = EMPTY;
          end
        end else if (in_valid) begin
          skid_next  = in_word;
          state_next = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so the input is never taken.
        if (out_ready) begin
          main_next  = skid_word;
          state_next = ONE;
        end
      end
      default: begin
        main_next  = BUBBLE;
        state_next = EMPTY;
      end
    endcase
    // Flush discards everything held and anything offered this cycle; a word
    // leaving on the output this cycle has already been delivered.
    if (flush) begin
      state_next = EMPTY;
      main_next  = BUBBLE;
      skid_next  = skid_word;
    end
  end

  // State and entry registers; reset empties both entries immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_word <= BUBBLE;
      skid_word <= BUBBLE;
    end else begin
      state     <= state_next;
      main_word <= main_next;
      skid_word <= skid_next;
    end
  end

  // Saturating count of cycles where a word waits on a stalled consumer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 16'd0;
    end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
